// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op codes and widths for the multiply/divide unit
// Purpose: md_op encoding used by the decoder, md_calc and mul_div_unit.
//   The op field is 4 bits wide because MD_MTLO (8) does not fit in 3 bits.
package md_pkg;

  localparam int MD_OP_W = 4;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 4'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 4'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 4'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 4'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 4'd4;
  localparam logic [MD_OP_W-1:0] MD_MFHI  = 4'd5;
  localparam logic [MD_OP_W-1:0] MD_MFLO  = 4'd6;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 4'd7;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 4'd8;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_multicycle(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational 64-bit multiply/divide result generator
// Purpose: produces the {hi,lo} pair for mult/multu/div/divu in one step.
// Ports:
//   op    in   4      md_op code
//   srcA  in   WIDTH  dividend / multiplicand
//   srcB  in   WIDTH  divisor / multiplier
//   hi    out  WIDTH  product high half or remainder
//   lo    out  WIDTH  product low half or quotient
//   div0  out  1      divide op with a zero divisor
module md_calc
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MD_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   srcA,
  input  logic [WIDTH-1:0]   srcB,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               div0
);

  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic               b_zero;
  logic               s_ovf;
  logic [WIDTH-1:0]   dvs_s;
  logic [WIDTH-1:0]   dvs_u;
  logic [WIDTH-1:0]   quo_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   quo_u;
  logic [WIDTH-1:0]   rem_u;

  assign b_zero = (srcB == '0);
  assign div0   = b_zero && ((op == MD_DIV) || (op == MD_DIVU));

  // Sign-extend explicitly so the product is formed at full 2*WIDTH precision.
  assign prod_s = $signed({{WIDTH{srcA[WIDTH-1]}}, srcA}) *
                  $signed({{WIDTH{srcB[WIDTH-1]}}, srcB});
  assign prod_u = {{WIDTH{1'b0}}, srcA} * {{WIDTH{1'b0}}, srcB};

  // MIN / -1 overflows; dividing by 1 instead yields the architected MIN rem 0.
  // A zero divisor is also replaced by 1 so the divider never sees x/0.
  assign s_ovf = (srcA == {1'b1, {(WIDTH-1){1'b0}}}) && (srcB == '1);
  assign dvs_s = (b_zero || s_ovf) ? WIDTH'(1) : srcB;
  assign dvs_u = b_zero ? WIDTH'(1) : srcB;

  // Signed / and % truncate toward zero; remainder takes the dividend's sign.
  assign quo_s = $signed(srcA) / $signed(dvs_s);
  assign rem_s = $signed(srcA) % $signed(dvs_s);
  assign quo_u = srcA / dvs_u;
  assign rem_u = srcA % dvs_u;

  always_comb begin
    hi = '0;
    lo = '0;
    case (op)
      MD_MULT:  {hi, lo} = prod_s;
      MD_MULTU: {hi, lo} = prod_u;
      MD_DIV:   begin hi = rem_s; lo = quo_s; end
      MD_DIVU:  begin hi = rem_u; lo = quo_u; end
      default:  begin hi = '0; lo = '0; end
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - EX-stage multiply/divide unit with HI/LO registers
// Purpose: runs mult/multu/div/divu as multi-cycle ops and mthi/mtlo as
//   single-cycle writes; exports busy for the hazard unit.
// Ports:
//   clk     in   1      clock
//   reset   in   1      asynchronous active-high reset
//   req     in   1      exception/interrupt request, blocks new launches/writes
//   start   in   1      launch a mult/multu/div/divu
//   op      in   4      md_op code
//   srcA    in   WIDTH  rs value
//   srcB    in   WIDTH  rt value
//   busy    out  1      operation in flight
//   mulOut  out  WIDTH  HI for mfhi, LO for mflo, else 0
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  input  logic               start,
  input  logic [MD_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   srcA,
  input  logic [WIDTH-1:0]   srcB,
  output logic               busy,
  output logic [WIDTH-1:0]   mulOut
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             res_skip;
  logic [WIDTH-1:0] calc_hi;
  logic [WIDTH-1:0] calc_lo;
  logic             calc_div0;
  logic             launch;
  logic             idle_ok;
  logic             is_mul;

  md_calc #(.WIDTH(WIDTH)) u_calc (
    .op   (op),
    .srcA (srcA),
    .srcB (srcB),
    .hi   (calc_hi),
    .lo   (calc_lo),
    .div0 (calc_div0)
  );

  assign idle_ok = !req && !busy;
  assign launch  = start && idle_ok && is_multicycle(op);
  assign is_mul  = (op == MD_MULT) || (op == MD_MULTU);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      busy     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi   <= '0;
      res_lo   <= '0;
      res_skip <= 1'b0;
    end else begin
      if (launch) begin
        count    <= is_mul ? MUL_LOAD : DIV_LOAD;
        busy     <= 1'b1;
        res_hi   <= calc_hi;
        res_lo   <= calc_lo;
        // A zero divisor still costs the full latency but must not touch HI/LO.
        res_skip <= calc_div0;
      end else if (count == CNT_ONE) begin
        count <= '0;
        busy  <= 1'b0;
        if (!res_skip) begin
          hi_q <= res_hi;
          lo_q <= res_lo;
        end
      end else if (count != '0) begin
        count <= count - CNT_ONE;
      end

      // Completion only happens while busy, so these never collide with it.
      if (idle_ok && (op == MD_MTHI)) hi_q <= srcA;
      if (idle_ok && (op == MD_MTLO)) lo_q <= srcA;
    end
  end

  always_comb begin
    mulOut = '0;
    if (op == MD_MFHI)      mulOut = hi_q;
    else if (op == MD_MFLO) mulOut = lo_q;
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        start;
  logic [3:0]  op;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic [31:0] mulOut;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .start  (start),
    .op     (op),
    .srcA   (srcA),
    .srcB   (srcB),
    .busy   (busy),
    .mulOut (mulOut)
  );

  always @(posedge clk) begin
    if (!reset && start && busy && !req) $error("start while busy");
  end

  task automatic read_hl(output logic [31:0] h, output logic [31:0] l);
    op = MD_MFHI; #1; h = mulOut;
    op = MD_MFLO; #1; l = mulOut;
    op = MD_NONE; #1;
  endtask

  // Launch an op for one edge, then count the negedges at which busy is high.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    @(negedge clk);
    op = o; srcA = a; srcB = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = MD_NONE;
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [31:0] h, l;
    reset = 1'b1; req = 1'b0; start = 1'b0; op = MD_NONE; srcA = '0; srcB = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else passed++;
    #1;
    total++; if (mulOut !== 32'h0) $display("FAIL reset_none got=%h exp=0", mulOut); else passed++;
    read_hl(h, l);
    total++; if (h !== 32'h0) $display("FAIL reset_hi got=%h exp=0", h); else passed++;
    total++; if (l !== 32'h0) $display("FAIL reset_lo got=%h exp=0", l); else passed++;
  endtask

  task automatic test_mult;
    logic [31:0] h, l;
    int n;
    run_op(MD_MULT, 32'hFFFFFFFD, 32'd5, n);
    total++; if (n != 5) $display("FAIL mult_busy got=%0d exp=5", n); else passed++;
    read_hl(h, l);
    total++; if (h !== 32'hFFFFFFFF) $display("FAIL mult_hi got=%h exp=ffffffff", h); else passed++;
    total++; if (l !== 32'hFFFFFFF1) $display("FAIL mult_lo got=%h exp=fffffff1", l); else passed++;
    total++; if (mulOut !== 32'h0) $display("FAIL mult_none got=%h exp=0", mulOut); else passed++;
  endtask

  task automatic test_multu;
    logic [31:0] h, l;
    int n;
    run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, n);
    total++; if (n != 5) $display("FAIL multu_busy got=%0d exp=5", n); else passed++;
    read_hl(h, l);
    total++; if (h !== 32'h1) $display("FAIL multu_hi got=%h exp=1", h); else passed++;
    total++; if (l !== 32'hFFFFFFFE) $display("FAIL multu_lo got=%h exp=fffffffe", l); else passed++;
  endtask

  task automatic test_div;
    logic [31:0] h, l;
    int n;
    run_op(MD_DIV, 32'hFFFFFFF9, 32'd2, n);
    total++; if (n != 10) $display("FAIL div_busy got=%0d exp=10", n); else passed++;
    read_hl(h, l);
    total++; if (l !== 32'hFFFFFFFD) $display("FAIL div_lo got=%h exp=fffffffd", l); else passed++;
    total++; if (h !== 32'hFFFFFFFF) $display("FAIL div_hi got=%h exp=ffffffff", h); else passed++;

    run_op(MD_DIVU, 32'd7, 32'd0, n);
    total++; if (n != 10) $display("FAIL divu0_busy got=%0d exp=10", n); else passed++;
    read_hl(h, l);
    total++; if (h !== 32'hFFFFFFFF) $display("FAIL divu0_hi got=%h exp=ffffffff", h); else passed++;
    total++; if (l !== 32'hFFFFFFFD) $display("FAIL divu0_lo got=%h exp=fffffffd", l); else passed++;

    run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF, n);
    read_hl(h, l);
    total++; if (l !== 32'h80000000) $display("FAIL divovf_lo got=%h exp=80000000", l); else passed++;
    total++; if (h !== 32'h0) $display("FAIL divovf_hi got=%h exp=0", h); else passed++;

    run_op(MD_DIV, 32'd7, 32'hFFFFFFFE, n);
    read_hl(h, l);
    total++; if (l !== 32'hFFFFFFFD) $display("FAIL divneg_lo got=%h exp=fffffffd", l); else passed++;
    total++; if (h !== 32'h1) $display("FAIL divneg_hi got=%h exp=1", h); else passed++;

    run_op(MD_DIVU, 32'hFFFFFFFF, 32'h10, n);
    read_hl(h, l);
    total++; if (l !== 32'h0FFFFFFF) $display("FAIL divu_lo got=%h exp=0fffffff", l); else passed++;
    total++; if (h !== 32'hF) $display("FAIL divu_hi got=%h exp=f", h); else passed++;
  endtask

  task automatic test_move;
    logic [31:0] h, l;
    int n;
    @(negedge clk); op = MD_MTHI; srcA = 32'h1234;
    @(negedge clk); op = MD_NONE;
    read_hl(h, l);
    total++; if (h !== 32'h1234) $display("FAIL mthi got=%h exp=1234", h); else passed++;
    @(negedge clk); op = MD_MTLO; srcA = 32'h5678;
    @(negedge clk); op = MD_NONE;
    read_hl(h, l);
    total++; if (l !== 32'h5678) $display("FAIL mtlo got=%h exp=5678", l); else passed++;

    // Reads and moves while busy: reads see old values, moves are dropped.
    @(negedge clk); op = MD_MULT; srcA = 32'd3; srcB = 32'd4; start = 1'b1;
    @(negedge clk); start = 1'b0; op = MD_MTLO; srcA = 32'hDEAD;
    @(negedge clk); op = MD_NONE;
    total++; if (busy !== 1'b1) $display("FAIL move_busy got=%b exp=1", busy); else passed++;
    read_hl(h, l);
    total++; if (h !== 32'h1234) $display("FAIL busy_read_hi got=%h exp=1234", h); else passed++;
    total++; if (l !== 32'h5678) $display("FAIL busy_read_lo got=%h exp=5678", l); else passed++;
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    total++; if (busy !== 1'b0) $display("FAIL move_done got=%b exp=0", busy); else passed++;
    read_hl(h, l);
    total++; if (h !== 32'h0) $display("FAIL mult34_hi got=%h exp=0", h); else passed++;
    total++; if (l !== 32'd12) $display("FAIL mult34_lo got=%h exp=c", l); else passed++;
  endtask

  task automatic test_req;
    logic [31:0] h, l;
    @(negedge clk); op = MD_MULT; srcA = 32'd9; srcB = 32'd9; start = 1'b1; req = 1'b1;
    @(negedge clk); start = 1'b0; req = 1'b0; op = MD_NONE;
    total++; if (busy !== 1'b0) $display("FAIL req_busy got=%b exp=0", busy); else passed++;
    repeat (6) @(negedge clk);
    read_hl(h, l);
    total++; if (h !== 32'h0) $display("FAIL req_hi got=%h exp=0", h); else passed++;
    total++; if (l !== 32'd12) $display("FAIL req_lo got=%h exp=c", l); else passed++;
    @(negedge clk); op = MD_MTHI; srcA = 32'hAAAA; req = 1'b1;
    @(negedge clk); op = MD_NONE; req = 1'b0;
    read_hl(h, l);
    total++; if (h !== 32'h0) $display("FAIL req_mthi got=%h exp=0", h); else passed++;
  endtask

  task automatic test_req_inflight;
    logic [31:0] h, l;
    int n;
    @(negedge clk); op = MD_DIV; srcA = 32'd100; srcB = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0; op = MD_NONE;
    n = 0;
    while (busy && n < 100) begin
      n++;
      req = (n == 3);
      @(negedge clk);
    end
    req = 1'b0;
    total++; if (n != 10) $display("FAIL reqfl_busy got=%0d exp=10", n); else passed++;
    read_hl(h, l);
    total++; if (l !== 32'd14) $display("FAIL reqfl_lo got=%h exp=e", l); else passed++;
    total++; if (h !== 32'd2) $display("FAIL reqfl_hi got=%h exp=2", h); else passed++;
  endtask

  task automatic test_reset_mid;
    logic [31:0] h, l;
    int n;
    @(negedge clk); op = MD_MULTU; srcA = 32'd10; srcB = 32'd10; start = 1'b1;
    @(negedge clk); start = 1'b0; op = MD_NONE;
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL mid_busy got=%b exp=1", busy); else passed++;
    #2 reset = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", busy); else passed++;
    read_hl(h, l);
    total++; if (h !== 32'h0) $display("FAIL mid_rst_hi got=%h exp=0", h); else passed++;
    total++; if (l !== 32'h0) $display("FAIL mid_rst_lo got=%h exp=0", l); else passed++;
    @(negedge clk); reset = 1'b0;
    repeat (12) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL post_rst_busy got=%b exp=0", busy); else passed++;
    read_hl(h, l);
    total++; if (l !== 32'h0) $display("FAIL post_rst_lo got=%h exp=0", l); else passed++;
    run_op(MD_MULT, 32'd6, 32'd7, n);
    total++; if (n != 5) $display("FAIL again_busy got=%0d exp=5", n); else passed++;
    read_hl(h, l);
    total++; if (l !== 32'd42) $display("FAIL again_lo got=%h exp=2a", l); else passed++;
    total++; if (h !== 32'h0) $display("FAIL again_hi got=%h exp=0", h); else passed++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_move();
    test_req();
    test_req_inflight();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
